// File: rtl/vram_slot_sequencer.sv
// vram_slot_sequencer: eight-slot RAM time-slot scheduler
// shared by the layer A/B fetch, the fix-layer fetch and a CPU requester.
module vram_slot_sequencer #(
  parameter logic [2:0] RESET_SLOT = 3'd7,
  parameter bit         DONATE_EN  = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PE,
  input  logic       LINE_START,
  input  logic       LAYA_EN,
  input  logic       LAYB_EN,
  input  logic       FIX_EN,
  input  logic       CPU_REQ,
  input  logic       CPU_RNW,
  output logic [2:0] SLOT,
  output logic       ATTR,
  output logic       SELA,
  output logic       SELAn,
  output logic       SELB,
  output logic       SELBn,
  output logic       SELC,
  output logic       SELCn,
  output logic       CPU_GRANT,
  output logic       RAM_WE,
  output logic       CPU_ACK,
  output logic [2:0] TILE_LATCH,
  output logic       CPU_WAIT
);

  typedef enum logic [2:0] {
    SRC_IDLE,
    SRC_LAYA,
    SRC_LAYB,
    SRC_FIX,
    SRC_CPU
  } src_t;

  logic [2:0] slot_q, slot_d;
  src_t       src_q, src_d;
  logic       rnw_q, rnw_d;
  logic       ack_q, ack_d;
  logic [2:0] lat_q, lat_d;

  logic       cpu_slot;
  logic       lay_en;
  src_t       lay_src;
  logic       cpu_ok;

  // Slot/source registers; a reset drops any grant without an ACK.
  always_ff @(posedge CLK) begin
    if (RST) begin
      slot_q <= RESET_SLOT;
      src_q  <= SRC_IDLE;
      rnw_q  <= 1'b1;
      ack_q  <= 1'b0;
      lat_q  <= 3'b000;
    end else begin
      slot_q <= slot_d;
      src_q  <= src_d;
      rnw_q  <= rnw_d;
      ack_q  <= ack_d;
      lat_q  <= lat_d;
    end
  end

  // Slot exit pulses and source resolution for the slot being entered.
  always_comb begin
    slot_d   = slot_q;
    src_d    = src_q;
    rnw_d    = rnw_q;
    ack_d    = 1'b0;
    lat_d    = 3'b000;
    cpu_slot = 1'b0;
    lay_en   = 1'b0;
    lay_src  = SRC_IDLE;
    cpu_ok   = 1'b0;
    if (PE) begin
      ack_d = (src_q == SRC_CPU);
      lat_d = {src_q == SRC_FIX,
               src_q == SRC_LAYB,
               src_q == SRC_LAYA};
      slot_d = LINE_START ? 3'd0
                          : slot_q + 3'd1;
      // The edge that ACKs a request may not regrant it.
      cpu_ok = CPU_REQ && !ack_d;
      unique case (slot_d[1:0])
        2'd0: begin
          lay_en  = LAYA_EN;
          lay_src = SRC_LAYA;
        end
        2'd1: begin
          lay_en  = LAYB_EN;
          lay_src = SRC_LAYB;
        end
        2'd2: begin
          lay_en  = FIX_EN;
          lay_src = SRC_FIX;
        end
        default: cpu_slot = 1'b1;
      endcase
      if (cpu_slot)
        src_d = cpu_ok ? SRC_CPU : SRC_IDLE;
      else if (lay_en)
        src_d = lay_src;
      else if (DONATE_EN && cpu_ok)
        src_d = SRC_CPU;
      else
        src_d = SRC_IDLE;
      if (src_d == SRC_CPU)
        rnw_d = CPU_RNW;
    end
  end

  assign SLOT       = slot_q;
  assign ATTR       = slot_q[2];
  assign SELA       = (src_q == SRC_LAYA);
  assign SELB       = (src_q == SRC_LAYB);
  assign SELC       = (src_q == SRC_CPU) ||
                      (src_q == SRC_IDLE);
  assign SELAn      = ~SELA;
  assign SELBn      = ~SELB;
  assign SELCn      = ~SELC;
  assign CPU_GRANT  = (src_q == SRC_CPU);
  assign RAM_WE     = CPU_GRANT & ~rnw_q;
  assign CPU_ACK    = ack_q;
  assign TILE_LATCH = lat_q;
  assign CPU_WAIT   = CPU_REQ & ~CPU_GRANT
                      & ~ack_q;

endmodule

// File: tb/tb_vram_slot_sequencer.sv
// tb_vram_slot_sequencer: directed bench for
// the VRAM slot sequencer.
module tb_vram_slot_sequencer;

  logic       clk = 1'b0;
  logic       rst, pe, line_start;
  logic       laya_en, layb_en, fix_en;
  logic       cpu_req, cpu_rnw;
  logic [2:0] slot;
  logic       attr;
  logic       sela, selan, selb, selbn;
  logic       selc, selcn;
  logic       cpu_grant, ram_we, cpu_ack;
  logic [2:0] tile_latch;
  logic       cpu_wait;

  int checks = 0;
  int errors = 0;

  // {SELC, SELB, SELA}
  localparam logic [2:0] S_A = 3'b001;
  localparam logic [2:0] S_B = 3'b010;
  localparam logic [2:0] S_F = 3'b000;
  localparam logic [2:0] S_C = 3'b100;

  always #5 clk = ~clk;

  vram_slot_sequencer dut (
    .CLK        (clk),
    .RST        (rst),
    .PE         (pe),
    .LINE_START (line_start),
    .LAYA_EN    (laya_en),
    .LAYB_EN    (layb_en),
    .FIX_EN     (fix_en),
    .CPU_REQ    (cpu_req),
    .CPU_RNW    (cpu_rnw),
    .SLOT       (slot),
    .ATTR       (attr),
    .SELA       (sela),
    .SELAn      (selan),
    .SELB       (selb),
    .SELBn      (selbn),
    .SELC       (selc),
    .SELCn      (selcn),
    .CPU_GRANT  (cpu_grant),
    .RAM_WE     (ram_we),
    .CPU_ACK    (cpu_ack),
    .TILE_LATCH (tile_latch),
    .CPU_WAIT   (cpu_wait)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string      tag,
    input logic [2:0] s,
    input logic [2:0] sel,
    input logic       g,
    input logic       we,
    input logic       ack,
    input logic [2:0] lt,
    input logic       w
  );
    logic [13:0] obs, exp;
    logic [2:0]  obs_n;
    obs = {slot, attr, selc, selb, sela,
           cpu_grant, ram_we, cpu_ack,
           tile_latch, cpu_wait};
    exp = {s, s[2], sel, g, we, ack, lt, w};
    obs_n = {selcn, selbn, selan};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b",
             tag, obs, exp);
    end
    checks++;
    assert (obs_n === ~sel) else begin
      errors++;
      $error("FAIL %s_n obs=%b exp=%b",
             tag, obs_n, ~sel);
    end
  endtask

  logic [2:0] sel_t [8];
  logic [2:0] lat_t [8];

  initial begin
    sel_t = '{S_A, S_B, S_F, S_C,
              S_A, S_B, S_F, S_C};
    lat_t = '{3'b000, 3'b001, 3'b010, 3'b100,
              3'b000, 3'b001, 3'b010, 3'b100};
    rst = 1'b1;
    pe = 1'b1;
    line_start = 1'b0;
    laya_en = 1'b1;
    layb_en = 1'b1;
    fix_en = 1'b1;
    cpu_req = 1'b0;
    cpu_rnw = 1'b1;
    tick();
    chk("rst", 3'd7, S_C, 0, 0, 0, 3'b000, 0);
    rst = 1'b0;

    // free-running base schedule
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("base%0d", i),
          3'(i % 8), sel_t[i % 8],
          0, 0, 0, lat_t[i % 8], 0);
    end

    // write request raised in slot 0
    cpu_req = 1'b1;
    cpu_rnw = 1'b0;
    #1;
    chk("w0", 3'd0, S_A, 0, 0, 0, 3'b000, 1);
    tick();
    chk("w1", 3'd1, S_B, 0, 0, 0, 3'b001, 1);
    tick();
    chk("w2", 3'd2, S_F, 0, 0, 0, 3'b010, 1);
    tick();
    chk("g3", 3'd3, S_C, 1, 1, 0, 3'b100, 0);
    tick();
    chk("a4", 3'd4, S_A, 0, 0, 1, 3'b000, 0);
    cpu_req = 1'b0;
    tick();
    chk("s5", 3'd5, S_B, 0, 0, 0, 3'b001, 0);

    // layer A off, read request held
    laya_en = 1'b0;
    cpu_req = 1'b1;
    cpu_rnw = 1'b1;
    tick();
    chk("d6", 3'd6, S_F, 0, 0, 0, 3'b010, 1);
    tick();
    chk("d7", 3'd7, S_C, 1, 0, 0, 3'b100, 0);
    tick();
    chk("d0", 3'd0, S_C, 0, 0, 1, 3'b000, 0);
    tick();
    chk("d1", 3'd1, S_B, 0, 0, 0, 3'b000, 1);
    tick();
    chk("d2", 3'd2, S_F, 0, 0, 0, 3'b010, 1);
    tick();
    chk("d3", 3'd3, S_C, 1, 0, 0, 3'b100, 0);
    tick();
    chk("d4", 3'd4, S_C, 0, 0, 1, 3'b000, 0);
    cpu_req = 1'b0;
    tick();
    chk("d5", 3'd5, S_B, 0, 0, 0, 3'b000, 0);
    tick();
    tick();
    chk("i7", 3'd7, S_C, 0, 0, 0, 3'b100, 0);
    tick();
    chk("i0", 3'd0, S_C, 0, 0, 0, 3'b000, 0);
    tick();
    chk("i1", 3'd1, S_B, 0, 0, 0, 3'b000, 0);
    tick();
    tick();
    chk("i3", 3'd3, S_C, 0, 0, 0, 3'b100, 0);
    cpu_req = 1'b1;
    cpu_rnw = 1'b0;
    #1;
    chk("w3", 3'd3, S_C, 0, 0, 0, 3'b100, 1);
    tick();
    chk("g4", 3'd4, S_C, 1, 1, 0, 3'b000, 0);
    tick();
    chk("a5", 3'd5, S_B, 0, 0, 1, 3'b000, 0);

    // PE every fourth clock
    laya_en = 1'b1;
    pe = 1'b0;
    tick();
    chk("h5", 3'd5, S_B, 0, 0, 0, 3'b000, 1);
    pe = 1'b1;
    tick();
    pe = 1'b0;
    chk("p6", 3'd6, S_F, 0, 0, 0, 3'b010, 1);
    tick();
    chk("q6", 3'd6, S_F, 0, 0, 0, 3'b000, 1);
    tick();
    tick();
    pe = 1'b1;
    tick();
    pe = 1'b0;
    chk("p7", 3'd7, S_C, 1, 1, 0, 3'b100, 0);
    tick();
    chk("q7", 3'd7, S_C, 1, 1, 0, 3'b000, 0);
    tick();
    tick();
    pe = 1'b1;
    tick();
    pe = 1'b0;
    chk("p0", 3'd0, S_A, 0, 0, 1, 3'b000, 0);
    cpu_req = 1'b0;
    tick();
    chk("q0", 3'd0, S_A, 0, 0, 0, 3'b000, 0);
    pe = 1'b1;

    // LINE_START out of a granted slot 3
    tick();
    chk("l1", 3'd1, S_B, 0, 0, 0, 3'b001, 0);
    tick();
    chk("l2", 3'd2, S_F, 0, 0, 0, 3'b010, 0);
    cpu_req = 1'b1;
    cpu_rnw = 1'b1;
    tick();
    chk("l3", 3'd3, S_C, 1, 0, 0, 3'b100, 0);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    chk("ls0", 3'd0, S_A, 0, 0, 1, 3'b000, 0);
    cpu_req = 1'b0;

    // reset during a granted slot 7
    for (int i = 0; i < 6; i++) tick();
    chk("r6", 3'd6, S_F, 0, 0, 0, 3'b010, 0);
    cpu_req = 1'b1;
    cpu_rnw = 1'b0;
    tick();
    chk("r7", 3'd7, S_C, 1, 1, 0, 3'b100, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr", 3'd7, S_C, 0, 0, 0, 3'b000, 1);
    tick();
    chk("r0", 3'd0, S_A, 0, 0, 0, 3'b000, 1);
    tick();
    tick();
    tick();
    chk("r3", 3'd3, S_C, 1, 1, 0, 3'b100, 0);
    tick();
    chk("r4", 3'd4, S_A, 0, 0, 1, 3'b000, 0);
    cpu_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
